// File: rtl/arb_pkg.sv
// Shared types for the two-master AXI-lite read arbiter.
// Bus widths mirror the core's AXI address/data bus defines.
package arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    M0   = 2'b01,
    M1   = 2'b10
  } arb_owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the read arbiter.
// ARB_ROUND_ROBIN_EN: on a tie, grant the master that did not win last time.
// Otherwise m1 always beats m0 and the last grant is ignored.
module arb_pick
  import arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  arb_owner_e i_last_grant,
  output arb_owner_e o_grant
);

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last_grant;
`endif

  // Pick a winner; a lone requester always wins.
  always_comb begin
    o_grant = NONE;
    if (i_req0 && i_req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant = (i_last_grant == M1) ? M0 : M1;
`else
      o_grant = M1;
`endif
    end else if (i_req1) begin
      o_grant = M1;
    end else if (i_req0) begin
      o_grant = M0;
    end
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI-lite read-channel arbiter (IFU = m0, LSU = m1).
// One read in flight at a time: IDLE arbitrates, ADDR forwards the owner's
// AR, DATA forwards the slave's R back to the owner.
// Optional macro ARB_ROUND_ROBIN_EN switches tie-breaking to round robin.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and the arbiter only passes ready/valid
// through for the current owner, holding every other master's ready/valid low.
module axi_lite_rd_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        arb_owner,
  output logic [1:0]        dbg_state
);

  arb_state_e r_state, w_state_nxt;
  arb_owner_e r_owner, w_owner_nxt;
  arb_owner_e r_last_grant, w_last_nxt;
  arb_owner_e w_pick;
  logic       w_own0, w_own1;
  logic       w_ar_hs, w_r_hs;

  arb_pick u_pick (
    .i_req0      (m0_arvalid),
    .i_req1      (m1_arvalid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_pick)
  );

  assign w_own0    = (r_owner == M0);
  assign w_own1    = (r_owner == M1);
  assign w_ar_hs   = s_arvalid && s_arready;
  assign w_r_hs    = s_rvalid && s_rready;
  assign arb_owner = r_owner;
  assign dbg_state = r_state;

  // State, owner and last grant registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= NONE;
      r_last_grant <= M1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Next state: grant once in IDLE, then hold it until the R beat completes.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_pick != NONE) begin
          w_owner_nxt = w_pick;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (w_ar_hs) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_r_hs) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
          w_owner_nxt = NONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_owner_nxt = NONE;
      end
    endcase
  end

  // Output steering: only the owner sees the slave; everything else reads 0.
  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_rresp   = 2'b00;
    if (r_state == ADDR) begin
      if (w_own0) begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end else if (w_own1) begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end
    end else if (r_state == DATA) begin
      if (w_own0) begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        s_rready  = m0_rready;
      end else if (w_own1) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        s_rready  = m1_rready;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter with a transaction-level model,
// per-master expected-data queues and a grant-order log.
module tb_axi_lite_rd_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready = 1'b1, m1_rready = 1'b1;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [1:0]  arb_owner, dbg_state;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [1:0]  grant_log[$];

  int         sl_ar_delay = 0;
  int         sl_r_delay  = 3;
  logic [1:0] sl_resp     = 2'b00;

  // clock / reset
  always #5 clk = ~clk;

  axi_lite_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .arb_owner(arb_owner), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] sl_data(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ 32'h0000_0413;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out, want handshake (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  // md_owner: -1 nobody, 0 IFU, 1 LSU; md_data: address already accepted.
  int md_owner = -1;
  bit md_data  = 1'b0;
  int md_last  = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_owner <= -1;
      md_data  <= 1'b0;
      md_last  <= 1;
    end else if (md_owner < 0) begin
      if (m0_arvalid && m1_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
        md_owner <= (md_last == 1) ? 0 : 1;
`else
        md_owner <= 1;
`endif
      end else if (m1_arvalid) begin
        md_owner <= 1;
      end else if (m0_arvalid) begin
        md_owner <= 0;
      end
      md_data <= 1'b0;
    end else if (!md_data) begin
      if ((md_owner == 0 ? m0_arvalid : m1_arvalid) && s_arready) md_data <= 1'b1;
    end else if (s_rvalid && (md_owner == 0 ? m0_rready : m1_rready)) begin
      md_last  <= md_owner;
      md_owner <= -1;
      md_data  <= 1'b0;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [1:0]  e_own, e_rr0, e_rr1;
    logic        e_sarv, e_ar0, e_ar1, e_srr, e_rv0, e_rv1;
    logic [31:0] e_saddr, e_rd0, e_rd1;
    e_own = (md_owner == 0) ? 2'b01 : (md_owner == 1) ? 2'b10 : 2'b00;
    e_sarv = 1'b0; e_ar0 = 1'b0; e_ar1 = 1'b0; e_srr = 1'b0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_saddr = '0; e_rd0 = '0; e_rd1 = '0;
    e_rr0 = 2'b00; e_rr1 = 2'b00;
    if (md_owner >= 0 && !md_data) begin
      if (md_owner == 0) begin
        e_sarv = m0_arvalid; e_saddr = m0_araddr; e_ar0 = s_arready;
      end else begin
        e_sarv = m1_arvalid; e_saddr = m1_araddr; e_ar1 = s_arready;
      end
    end else if (md_owner >= 0) begin
      if (md_owner == 0) begin
        e_rv0 = s_rvalid; e_rd0 = s_rdata; e_rr0 = s_rresp; e_srr = m0_rready;
      end else begin
        e_rv1 = s_rvalid; e_rd1 = s_rdata; e_rr1 = s_rresp; e_srr = m1_rready;
      end
    end
    check("arb_owner",  64'(arb_owner),  64'(e_own));
    check("s_arvalid",  64'(s_arvalid),  64'(e_sarv));
    check("s_araddr",   64'(s_araddr),   64'(e_saddr));
    check("m0_arready", 64'(m0_arready), 64'(e_ar0));
    check("m1_arready", 64'(m1_arready), 64'(e_ar1));
    check("s_rready",   64'(s_rready),   64'(e_srr));
    check("m0_rvalid",  64'(m0_rvalid),  64'(e_rv0));
    check("m1_rvalid",  64'(m1_rvalid),  64'(e_rv1));
    check("m0_rdata",   64'(m0_rdata),   64'(e_rd0));
    check("m1_rdata",   64'(m1_rdata),   64'(e_rd1));
    check("m0_rresp",   64'(m0_rresp),   64'(e_rr0));
    check("m1_rresp",   64'(m1_rresp),   64'(e_rr1));
  end

  // scoreboard: every delivered R beat must match the next expected one
  always @(negedge clk) begin
    logic [33:0] e;
    if (m0_rvalid && m0_rready) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL m0_r_unexpected: got data %08h, want no R beat", m0_rdata);
      end else begin
        e = exp_q0.pop_front();
        check("m0_r_beat", 64'({m0_rresp, m0_rdata}), 64'(e));
      end
    end
    if (m1_rvalid && m1_rready) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL m1_r_unexpected: got data %08h, want no R beat", m1_rdata);
      end else begin
        e = exp_q1.pop_front();
        check("m1_r_beat", 64'({m1_rresp, m1_rdata}), 64'(e));
      end
    end
  end

  // grant-order log (a grant starts whenever the owner leaves none)
  logic [1:0] prev_own = 2'b00;
  always @(negedge clk) begin
    if (arb_owner != 2'b00 && prev_own == 2'b00) grant_log.push_back(arb_owner);
    prev_own <= arb_owner;
  end

  // ---------------- slave responder ----------------
  logic        ar_hs_n = 1'b0, r_hs_n = 1'b0;
  logic [31:0] hs_addr_n = '0;
  always @(negedge clk) begin
    ar_hs_n   <= s_arvalid && s_arready;
    r_hs_n    <= s_rvalid && s_rready;
    hs_addr_n <= s_araddr;
  end

  initial begin : slave
    int          ar_wait, r_cnt;
    bit          busy;
    logic [31:0] a;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    busy = 1'b0; ar_wait = 0; r_cnt = 0; a = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        busy = 1'b0; ar_wait = 0;
      end else if (r_hs_n) begin
        s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; busy = 1'b0; ar_wait = 0;
      end else if (ar_hs_n) begin
        s_arready = 1'b0; busy = 1'b1; a = hs_addr_n; r_cnt = sl_r_delay;
      end else if (busy) begin
        if (!s_rvalid) begin
          if (r_cnt == 0) begin
            s_rvalid = 1'b1; s_rdata = sl_data(a); s_rresp = sl_resp;
          end else begin
            r_cnt--;
          end
        end
      end else if (s_arvalid) begin
        if (ar_wait >= sl_ar_delay) s_arready = 1'b1;
        else ar_wait++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic master_read(input int m, input logic [31:0] addr);
    int n;
    if (m == 0) begin m0_araddr = addr; m0_arvalid = 1'b1; end
    else        begin m1_araddr = addr; m1_arvalid = 1'b1; end
    n = 0;
    forever begin
      @(negedge clk);
      if (m == 0 ? m0_arready : m1_arready) break;
      n++;
      if (n > 300) begin timeout_fail(m == 0 ? "m0_ar_wait" : "m1_ar_wait"); break; end
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_arvalid = 1'b0; m0_araddr = '0; end
    else        begin m1_arvalid = 1'b0; m1_araddr = '0; end
    n = 0;
    forever begin
      @(negedge clk);
      if (m == 0 ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready)) break;
      n++;
      if (n > 300) begin timeout_fail(m == 0 ? "m0_r_wait" : "m1_r_wait"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_grants(input string name, input int exp_n, input logic [31:0] exp_packed);
    logic [31:0] packed_g;
    packed_g = '0;
    foreach (grant_log[i]) packed_g = (packed_g << 2) | 32'(grant_log[i]);
    check({name, "_count"}, 64'(grant_log.size()), 64'(exp_n));
    check({name, "_order"}, 64'(packed_g), 64'(exp_packed));
    grant_log.delete();
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;

    // reset state
    #3;
    check("rst_owner",    64'(arb_owner),  64'(2'b00));
    check("rst_state",    64'(dbg_state),  64'(IDLE));
    check("rst_s_arvalid",64'(s_arvalid),  64'(1'b0));
    check("rst_s_rready", 64'(s_rready),   64'(1'b0));
    check("rst_arready",  64'({m0_arready, m1_arready}), 64'(2'b00));
    check("rst_rvalid",   64'({m0_rvalid, m1_rvalid}),   64'(2'b00));
    check("rst_s_araddr", 64'(s_araddr),   64'(32'h0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: IFU alone
    grant_log.delete();
    exp_q0.push_back({2'b00, 32'h0000_0413});
    fork
      master_read(0, 32'h8000_0000);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_rvalid && n < 100);
        if (!m0_rvalid) timeout_fail("t1_rvalid");
        check("t1_owner_data", 64'(arb_owner), 64'(2'b01));
        check("t1_rdata",      64'(m0_rdata),  64'(32'h0000_0413));
        check("t1_rresp",      64'(m0_rresp),  64'(2'b00));
      end
    join
    check_grants("t1_grants", 1, 32'h1);

    // 2: simultaneous requests straight after reset
    do_reset();
    grant_log.delete();
    exp_q0.push_back({2'b00, 32'h0004_0413});
    exp_q1.push_back({2'b00, 32'h1000_0413});
    fork
      master_read(0, 32'h8000_0004);
      master_read(1, 32'h8000_1000);
    join
`ifdef ARB_ROUND_ROBIN_EN
    check_grants("t2_grants", 2, 32'h6);
`else
    check_grants("t2_grants", 2, 32'h9);
`endif

    // 3: IFU keeps requesting while LSU streams four reads
    exp_q0.push_back({2'b00, 32'h0010_0413});
    exp_q0.push_back({2'b00, 32'h0014_0413});
    for (int i = 0; i < 4; i++) exp_q1.push_back({2'b00, 32'h2000_0413 + (32'(i) << 18)});
    fork
      begin
        master_read(0, 32'h8000_0010);
        master_read(0, 32'h8000_0014);
      end
      begin
        for (int i = 0; i < 4; i++) master_read(1, 32'h8000_2000 + 32'(i) * 4);
      end
    join
`ifdef ARB_ROUND_ROBIN_EN
    check_grants("t3_grants", 6, 32'h66A);
`else
    check_grants("t3_grants", 6, 32'hAA5);
`endif

    // 4: slave stalls AR for 5 cycles; response is SLVERR
    sl_ar_delay = 5;
    sl_resp = 2'b10;
    exp_q1.push_back({2'b10, 32'h0020_0413});
    fork
      master_read(1, 32'h8000_0020);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (arb_owner == 2'b00 && n < 100);
        if (arb_owner == 2'b00) timeout_fail("t4_grant");
        for (int i = 0; i < 5; i++) begin
          check("t4_s_arvalid", 64'(s_arvalid),  64'(1'b1));
          check("t4_s_araddr",  64'(s_araddr),   64'(32'h8000_0020));
          check("t4_state",     64'(dbg_state),  64'(ADDR));
          check("t4_arready",   64'(m1_arready), 64'(1'b0));
          if (i < 4) @(negedge clk);
        end
      end
    join
    sl_ar_delay = 0;
    sl_resp = 2'b00;

    // 5: IFU holds rready low for 3 cycles
    m0_rready = 1'b0;
    exp_q0.push_back({2'b00, 32'h0030_0413});
    fork
      master_read(0, 32'h8000_0030);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_rvalid && n < 100);
        if (!m0_rvalid) timeout_fail("t5_rvalid");
        for (int i = 0; i < 3; i++) begin
          check("t5_s_rready", 64'(s_rready),  64'(1'b0));
          check("t5_rvalid",   64'(m0_rvalid), 64'(1'b1));
          check("t5_rdata",    64'(m0_rdata),  64'(32'h0030_0413));
          check("t5_state",    64'(dbg_state), 64'(DATA));
          if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        m0_rready = 1'b1;
        @(negedge clk);
        check("t5_s_rready_hi", 64'(s_rready), 64'(1'b1));
        @(negedge clk);
        check("t5_idle_state", 64'(dbg_state), 64'(IDLE));
        check("t5_idle_owner", 64'(arb_owner), 64'(2'b00));
      end
    join

    // 6: reset during DATA abandons the read
    m0_araddr = 32'h8000_0050;
    m0_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_arready && n < 100);
    if (!m0_arready) timeout_fail("t6_ar");
    @(posedge clk); #1;
    m0_arvalid = 1'b0;
    m0_araddr = '0;
    #2 rst = 1'b1;
    #1;
    check("t6_owner",     64'(arb_owner), 64'(2'b00));
    check("t6_state",     64'(dbg_state), 64'(IDLE));
    check("t6_s_rready",  64'(s_rready),  64'(1'b0));
    check("t6_s_arvalid", 64'(s_arvalid), 64'(1'b0));
    check("t6_rvalid",    64'({m0_rvalid, m1_rvalid}), 64'(2'b00));
    check("t6_rdata",     64'(m0_rdata),  64'(32'h0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    exp_q0.push_back({2'b00, 32'h0040_0413});
    master_read(0, 32'h8000_0040);
    repeat (2) @(posedge clk);

    check("end_q0_empty", 64'(exp_q0.size()), 64'(0));
    check("end_q1_empty", 64'(exp_q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master, one-slave AXI-lite read-channel arbiter. It shares the instruction SRAM read port between the IFU (master 0) and the LSU load path (master 1).
- Sits between the core fetch/load units and the SRAM slave. Exactly one read transaction is in flight at a time.
- Write channels do not pass through this block. The LSU routes AW/W/B directly and does not issue a read while its own write is unacknowledged.

Parameters:
- ADDR_W, 32, AXI address width (matches `AXI_ADDR_BUS)
- DATA_W, 32, AXI data width (matches `AXI_DATA_BUS)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- m0_araddr  in  ADDR_W  IFU read address
- m0_arvalid  in  1  IFU AR valid
- m0_arready  out  1  IFU AR ready
- m0_rdata  out  DATA_W  IFU read data
- m0_rresp  out  2  IFU read response
- m0_rvalid  out  1  IFU R valid
- m0_rready  in  1  IFU R ready
- m1_araddr / m1_arvalid / m1_arready / m1_rdata / m1_rresp / m1_rvalid / m1_rready  same widths and directions as m0_*, LSU side
- s_araddr  out  ADDR_W  slave read address
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_rdata  in  DATA_W  slave read data
- s_rresp  in  2  slave read response
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- arb_owner  out  2  current owner: 00 none, 01 m0, 10 m1

Behaviour:
- States:
  - IDLE: no owner.
  - ADDR: owner's AR is forwarded to the slave.
  - DATA: slave R is forwarded to the owner.
- Registered: state, owner, last_grant (used by the optional feature).
- All other outputs are combinational from state/owner.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, owner=none, last_grant=m1.
  - Resulting outputs: every *_arready, *_rvalid, s_arvalid, s_rready = 0; all data/resp/addr outputs = 0; arb_owner=00.
- IDLE:
  - All arready=0, all rvalid=0.
  - If any m*_arvalid is high, latch the winner as owner and go to ADDR next cycle.
  - Arbitration latency is exactly 1 cycle.
  - Default priority is fixed: m1 beats m0 when both are requesting in the same cycle.
- ADDR:
  - s_araddr = owner araddr; s_arvalid = owner arvalid; owner arready = s_arready.
  - Non-owner arready = 0.
  - On the s_arvalid && s_arready handshake, go to DATA.
  - If the owner drops arvalid (protocol violation), the grant is held: no timeout, no re-arbitration.
- DATA:
  - s_arvalid = 0. Owner rvalid/rdata/rresp = s_rvalid/s_rdata/s_rresp; s_rready = owner rready.
  - Non-owner rvalid = 0 and rdata = 0.
  - On the s_rvalid && s_rready handshake, go to IDLE and update last_grant = owner.
- Back-to-back: the earliest next AR grant is 1 cycle after R completes, i.e. the IDLE arbitration cycle.
- Non-owner requests simply wait with arvalid held. They are never dropped.
- rresp is forwarded unmodified, including SLVERR.
- Reset asserted mid-ADDR or mid-DATA: the transaction is abandoned and no R is delivered to the owner.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the master that is NOT last_grant. A single requester always wins.
- Undefined: fixed m1 > m0 priority. last_grant is still maintained but unused.

Decomposition:
- Package arb_pkg holds:
  - state enum typedef {IDLE, ADDR, DATA} (2 bits)
  - owner enum typedef {NONE=2'b00, M0=2'b01, M1=2'b10}
- Widths come from defines.svh.
- One sub-module: arb_pick, a combinational winner select from (req0, req1, last_grant). It contains the `ifdef ARB_ROUND_ROBIN_EN logic.

Test Plan:
- m0 alone reads 0x8000_0000; slave arready at cycle 0, rvalid after 3 cycles with 0x0000_0413 -> m0 receives rdata 0x413, rresp 00; arb_owner 01 in ADDR/DATA; m1_rvalid never high.
- m0 and m1 assert arvalid in the same cycle (0x8000_0004 / 0x8000_1000) -> without macro, m1 is served first, then m0; with ARB_ROUND_ROBIN_EN after reset (last_grant=m1), m0 is served first.
- m0 holds arvalid continuously while m1 issues 4 back-to-back reads -> fixed priority: m0 stalls until m1 idles; RR: grants alternate m0, m1, m0, m1.
- Slave holds arready=0 for 5 cycles during ADDR -> s_arvalid stays 1, s_araddr stays stable, no state change.
- Owner holds rready=0 for 3 cycles while s_rvalid=1 -> s_rready=0, data held; completes on the rready cycle, IDLE next cycle.
- Assert rst during DATA -> all outputs 0 in the same cycle; arb_owner=00; after release, a fresh m0 read completes normally.
